button_event_decoder: RTL and testbench

- Consumes the clean, debounced button level from the input debouncer and turns it into single-cycle user-interface events.
- Events: press, release, short click, long press and auto-repeat while held.
- Sits between the debouncer and the control/menu logic, which reacts to events rather than to raw levels.
- Timing is counted in prescaled ticks derived from clk, so there is no second clock domain.

---
 rtl/button_event_decoder.sv | 145 ++++++++++++++
 tb/tb_button_event_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced button level into single-cycle
// press / release / short / long / auto-repeat events, timed in prescaled ticks.
module button_event_decoder #(
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int HOLD_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_db,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              short_pulse,
  output logic              long_pulse,
  output logic              repeat_pulse,
  output logic              held,
  output logic [HOLD_W-1:0] hold_ticks
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int REP_W = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

  if ((LONG_TICKS < 1) ||
      (longint'(LONG_TICKS) > ((longint'(1) << HOLD_W) - longint'(1)))) begin : g_long_chk
    $error("LONG_TICKS must be >= 1 and fit in HOLD_W bits");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG
  } state_t;

  state_t             state_q, state_d;
  logic               btn_q, btn_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               short_q, short_d;
  logic               long_q, long_d;
  logic               repeat_q, repeat_d;
  logic               rise, fall, tick;

  // Edge detection and the tick prescaler, restarted on every edge.
  always_comb begin
    btn_d = btn_db;
    rise  = btn_db & ~btn_q;
    fall  = ~btn_db & btn_q;
    tick  = (pre_q == PRE_W'(TICK_DIV - 1));
    if (rise || fall || tick) pre_d = '0;
    else                      pre_d = pre_q + PRE_W'(1);
  end

  // Next-state and registered event logic; a fall always beats a same-cycle tick.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESSED;
          press_d = 1'b1;
          hold_d  = '0;
          rep_d   = '0;
        end
      end
      S_PRESSED: begin
        if (fall) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (tick) begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_q + HOLD_W'(1) == HOLD_W'(LONG_TICKS)) begin
            state_d = S_LONG;
            long_d  = 1'b1;
            rep_d   = '0;
          end
        end
      end
      S_LONG: begin
        if (fall) begin
          state_d   = S_IDLE;
          release_d = 1'b1;
        end else if (tick) begin
          if (hold_q != '1) hold_d = hold_q + HOLD_W'(1);
          if (REPEAT_TICKS != 0) begin
            if (rep_q + REP_W'(1) == REP_W'(REPEAT_TICKS)) begin
              repeat_d = 1'b1;
              rep_d    = '0;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and event registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      btn_q     <= 1'b0;
      pre_q     <= '0;
      rep_q     <= '0;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn_d;
      pre_q     <= pre_d;
      rep_q     <= rep_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = (state_q != S_IDLE);
  assign hold_ticks    = hold_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2.
module tb_button_event_decoder;

  localparam int HOLD_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              btn_db = 1'b0;
  logic              press_pulse, release_pulse, short_pulse;
  logic              long_pulse, repeat_pulse, held;
  logic [HOLD_W-1:0] hold_ticks;

  int vectors = 0;
  int miscompares = 0;

  // Per-window event statistics gathered at each falling edge.
  int cyc = 0;
  int n_press, n_rel, n_short, n_long, n_rep, n_held;
  int t_press, t_rel, t_short, t_long, t_rep_first, t_rep_last;

  button_event_decoder #(
    .TICK_DIV    (4),
    .LONG_TICKS  (3),
    .REPEAT_TICKS(2),
    .HOLD_W      (HOLD_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_db       (btn_db),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held),
    .hold_ticks   (hold_ticks)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_rep = 0; n_held = 0;
    t_press = -1; t_rel = -1; t_short = -1; t_long = -1;
    t_rep_first = -1; t_rep_last = -1;
  endtask

  // Advance n cycles, sampling outputs on each falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (press_pulse)   begin n_press++; t_press = cyc; end
      if (release_pulse) begin n_rel++;   t_rel   = cyc; end
      if (short_pulse)   begin n_short++; t_short = cyc; end
      if (long_pulse)    begin n_long++;  t_long  = cyc; end
      if (repeat_pulse) begin
        n_rep++;
        if (t_rep_first < 0) t_rep_first = cyc;
        t_rep_last = cyc;
      end
      if (held) n_held++;
    end
  endtask

  int r, f, rr;

  initial begin
    clear_stats();

    // 1: reset, then idle
    step(3);
    reset = 1'b0;
    clear_stats();
    step(20);
    check_val("idle_press",  n_press, 0);
    check_val("idle_rel",    n_rel, 0);
    check_val("idle_short",  n_short, 0);
    check_val("idle_long",   n_long, 0);
    check_val("idle_rep",    n_rep, 0);
    check_val("idle_held",   n_held, 0);
    check_val("idle_hold",   hold_ticks, 0);

    // 2: short press of 6 cycles
    clear_stats();
    r = cyc; btn_db = 1'b1;
    step(6);
    f = cyc; btn_db = 1'b0;
    step(6);
    check_val("s2_n_press",  n_press, 1);
    check_val("s2_t_press",  t_press, r + 1);
    check_val("s2_n_rel",    n_rel, 1);
    check_val("s2_t_rel",    t_rel, f + 1);
    check_val("s2_n_short",  n_short, 1);
    check_val("s2_t_short",  t_short, f + 1);
    check_val("s2_n_long",   n_long, 0);
    check_val("s2_held_len", n_held, 6);
    check_val("s2_hold",     hold_ticks, 1);
    step(6);
    check_val("s2_hold_kept", hold_ticks, 1);

    // 3: long press of 30 cycles with auto-repeat
    clear_stats();
    r = cyc; btn_db = 1'b1;
    step(30);
    f = cyc; btn_db = 1'b0;
    step(6);
    check_val("s3_n_long",   n_long, 1);
    check_val("s3_t_long",   t_long, r + 13);
    check_val("s3_n_rep",    n_rep, 2);
    check_val("s3_rep1",     t_rep_first, r + 21);
    check_val("s3_rep2",     t_rep_last, r + 29);
    check_val("s3_n_rel",    n_rel, 1);
    check_val("s3_t_rel",    t_rel, f + 1);
    check_val("s3_n_short",  n_short, 0);
    check_val("s3_hold",     hold_ticks, 7);
    step(6);

    // 4: fall coincides with the third tick -> still a short click
    clear_stats();
    r = cyc; btn_db = 1'b1;
    step(12);
    f = cyc; btn_db = 1'b0;
    step(8);
    check_val("s4_n_short",  n_short, 1);
    check_val("s4_t_short",  t_short, f + 1);
    check_val("s4_n_rel",    n_rel, 1);
    check_val("s4_t_rel",    t_rel, f + 1);
    check_val("s4_n_long",   n_long, 0);
    check_val("s4_n_rep",    n_rep, 0);

    // 5: reset while in LONG with the button still down
    clear_stats();
    r = cyc; btn_db = 1'b1;
    step(16);
    check_val("s5_pre_long", n_long, 1);
    check_val("s5_pre_held", held, 1);
    reset = 1'b1;
    step(1);
    check_val("s5_rst_held", held, 0);
    check_val("s5_rst_hold", hold_ticks, 0);
    check_val("s5_rst_pulses",
              {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse}, 0);
    rr = cyc; reset = 1'b0;
    clear_stats();
    step(5);
    check_val("s5_n_press",  n_press, 1);
    check_val("s5_t_press",  t_press, rr + 1);
    check_val("s5_n_rel",    n_rel, 0);
    check_val("s5_n_short",  n_short, 0);
    btn_db = 1'b0;
    step(6);

    // 6: single-cycle press
    clear_stats();
    r = cyc; btn_db = 1'b1;
    step(1);
    btn_db = 1'b0;
    step(6);
    check_val("s6_t_press",  t_press, r + 1);
    check_val("s6_t_rel",    t_rel, r + 2);
    check_val("s6_t_short",  t_short, r + 2);
    check_val("s6_n_short",  n_short, 1);
    check_val("s6_held_len", n_held, 1);
    check_val("s6_hold",     hold_ticks, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
